// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 interrupt controller: register map addresses,
// STATUS bit positions, CAUSE field offsets and a pointer-width helper.
package cp0_pkg;

    localparam int unsigned REG_ADDR_W = 3;

    localparam logic [REG_ADDR_W-1:0] ADDR_STATUS = 3'd0;
    localparam logic [REG_ADDR_W-1:0] ADDR_MASK   = 3'd1;
    localparam logic [REG_ADDR_W-1:0] ADDR_CAUSE  = 3'd2;
    localparam logic [REG_ADDR_W-1:0] ADDR_EPC    = 3'd3;
    localparam logic [REG_ADDR_W-1:0] ADDR_DEPTH  = 3'd4;

    localparam int unsigned STATUS_IE  = 0;
    localparam int unsigned STATUS_ERR = 1;

    localparam int unsigned CAUSE_PEND_LSB = 0;
    localparam int unsigned CAUSE_ID_LSB   = 16;

    // Index width for an n-entry array; never below one bit.
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cp0_epc_stack.sv
// LIFO of {resume PC, interrupt id} frames for nested handlers.
// Ports: clk/rst_n; push with push_pc/push_id; pop; wr_top/wr_pc replaces the
// top PC; top_pc/top_id (zero when empty), depth, full, empty.
module cp0_epc_stack
    import cp0_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ID_W       = 2,
    parameter int unsigned NEST_DEPTH = 4
)(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            push,
    input  logic [DATA_W-1:0]               push_pc,
    input  logic [ID_W-1:0]                 push_id,
    input  logic                            pop,
    input  logic                            wr_top,
    input  logic [DATA_W-1:0]               wr_pc,
    output logic [DATA_W-1:0]               top_pc,
    output logic [ID_W-1:0]                 top_id,
    output logic [$clog2(NEST_DEPTH+1)-1:0] depth,
    output logic                            full,
    output logic                            empty
);

    localparam int unsigned DEPTH_W = $clog2(NEST_DEPTH + 1);
    localparam int unsigned PTR_W   = ptr_w(NEST_DEPTH);

    logic [DATA_W-1:0]  pc_mem [NEST_DEPTH];
    logic [ID_W-1:0]    id_mem [NEST_DEPTH];
    logic [DEPTH_W-1:0] cnt;
    logic [PTR_W-1:0]   top_idx;
    logic [PTR_W-1:0]   push_idx;
    logic               do_push;
    logic               do_pop;
    logic               do_wr;

    assign empty    = (cnt == '0);
    assign full     = (cnt == DEPTH_W'(NEST_DEPTH));
    assign top_idx  = PTR_W'(cnt - DEPTH_W'(1));
    assign push_idx = PTR_W'(cnt);

    // Pop beats push beats top rewrite; the controller never pushes and pops together.
    assign do_pop  = pop && !empty;
    assign do_push = push && !full && !do_pop;
    assign do_wr   = wr_top && !empty && !do_pop && !push;

    // Occupancy counter; reset empties the stack regardless of memory contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (do_pop) begin
            cnt <= cnt - DEPTH_W'(1);
        end else if (do_push) begin
            cnt <= cnt + DEPTH_W'(1);
        end
    end

    // Frame storage; entries above depth are don't-care.
    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[push_idx] <= push_pc;
            id_mem[push_idx] <= push_id;
        end else if (do_wr) begin
            pc_mem[top_idx] <= wr_pc;
        end
    end

    assign top_pc = empty ? '0 : pc_mem[top_idx];
    assign top_id = empty ? '0 : id_mem[top_idx];
    assign depth  = cnt;

endmodule

// File: rtl/cp0_irq_ctrl.sv
// CP0 interrupt controller: pending latch, fixed-priority arbitration,
// request/ack handshake and nested-handler EPC stack.
// Ports: in_CLK/in_RST_N; register write (in_WE, in_rW, in_W) and read
// (in_rA -> out_A); in_irq lines; in_pc/in_ack/in_eret from the pipeline;
// out_irq_req/out_irq_id/out_vector request; out_epc, out_IE, out_INM, out_depth.
module cp0_irq_ctrl
    import cp0_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NUM_IRQ    = 4,
    parameter int unsigned NEST_DEPTH = 4,
    parameter bit          IRQ_EDGE   = 1'b1,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter int unsigned VEC_STRIDE = 16
)(
    input  logic                            in_CLK,
    input  logic                            in_RST_N,
    input  logic                            in_WE,
    input  logic [2:0]                      in_rW,
    input  logic [DATA_W-1:0]               in_W,
    input  logic [2:0]                      in_rA,
    output logic [DATA_W-1:0]               out_A,
    input  logic [NUM_IRQ-1:0]              in_irq,
    input  logic [DATA_W-1:0]               in_pc,
    input  logic                            in_ack,
    input  logic                            in_eret,
    output logic                            out_irq_req,
    output logic [$clog2(NUM_IRQ)-1:0]      out_irq_id,
    output logic [DATA_W-1:0]               out_vector,
    output logic [DATA_W-1:0]               out_epc,
    output logic                            out_IE,
    output logic [NUM_IRQ-1:0]              out_INM,
    output logic [$clog2(NEST_DEPTH+1)-1:0] out_depth
);

    localparam int unsigned ID_W    = $clog2(NUM_IRQ);
    localparam int unsigned DEPTH_W = $clog2(NEST_DEPTH + 1);

    logic               ie;
    logic               err;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pend_nxt;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] sw_set;
    logic [NUM_IRQ-1:0] cand_vec;
    logic               cand_vld;
    logic [ID_W-1:0]    cand_id;
    logic               req;
    logic               ack;
    logic               wr_status;
    logic               wr_mask;
    logic               wr_cause;
    logic               wr_epc;
    logic [DATA_W-1:0]  top_pc;
    logic [ID_W-1:0]    top_id;
    logic [DEPTH_W-1:0] depth;
    logic               stk_full;
    logic               stk_empty;

    assign wr_status = in_WE && (in_rW == ADDR_STATUS);
    assign wr_mask   = in_WE && (in_rW == ADDR_MASK);
    assign wr_cause  = in_WE && (in_rW == ADDR_CAUSE);
    assign wr_epc    = in_WE && (in_rW == ADDR_EPC);

    // Fixed priority: lowest enabled pending index wins.
    assign cand_vec = pending & mask;
    always_comb begin
        cand_vld = 1'b0;
        cand_id  = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (cand_vec[i]) begin
                cand_vld = 1'b1;
                cand_id  = ID_W'(i);
            end
        end
    end

    // Preempt only with a strictly higher-priority id than the running handler.
    assign req = ie && cand_vld && !stk_full && (stk_empty || (cand_id < top_id));
    // eret takes precedence over a same-cycle ack.
    assign ack = in_ack && req && !in_eret;

    // Pending update; a fresh edge or software set wins over the ack clear.
    always_comb begin
        rise   = in_irq & ~irq_q;
        sw_set = wr_cause ? in_W[NUM_IRQ-1:0] : '0;
        if (IRQ_EDGE) begin
            pend_nxt = pending;
            if (ack) begin
                pend_nxt[cand_id] = 1'b0;
            end
            pend_nxt = pend_nxt | rise | sw_set;
        end else begin
            pend_nxt = in_irq | sw_set;
        end
    end

    // Control/status registers; handshake-driven IE changes override software writes.
    always_ff @(posedge in_CLK or negedge in_RST_N) begin
        if (!in_RST_N) begin
            ie      <= 1'b1;
            err     <= 1'b0;
            mask    <= '0;
            pending <= '0;
            irq_q   <= '0;
        end else begin
            irq_q   <= in_irq;
            pending <= pend_nxt;
            if (ack) begin
                ie <= 1'b0;
            end else if (in_eret) begin
                ie <= 1'b1;
            end else if (wr_status) begin
                ie <= in_W[STATUS_IE];
            end
            if (in_eret && stk_empty) begin
                err <= 1'b1;
            end else if (wr_status && in_W[STATUS_ERR]) begin
                err <= 1'b0;
            end
            if (wr_mask) begin
                mask <= in_W[NUM_IRQ-1:0];
            end
        end
    end

    cp0_epc_stack #(
        .DATA_W     (DATA_W),
        .ID_W       (ID_W),
        .NEST_DEPTH (NEST_DEPTH)
    ) u_stack (
        .clk     (in_CLK),
        .rst_n   (in_RST_N),
        .push    (ack),
        .push_pc (in_pc),
        .push_id (cand_id),
        .pop     (in_eret),
        .wr_top  (wr_epc),
        .wr_pc   (in_W),
        .top_pc  (top_pc),
        .top_id  (top_id),
        .depth   (depth),
        .full    (stk_full),
        .empty   (stk_empty)
    );

    // Register read port.
    always_comb begin
        out_A = '0;
        case (in_rA)
            ADDR_STATUS: begin
                out_A[STATUS_IE]  = ie;
                out_A[STATUS_ERR] = err;
            end
            ADDR_MASK:  out_A[NUM_IRQ-1:0] = mask;
            ADDR_CAUSE: begin
                out_A[CAUSE_PEND_LSB +: NUM_IRQ] = pending;
                out_A[CAUSE_ID_LSB +: ID_W]      = top_id;
            end
            ADDR_EPC:   out_A = top_pc;
            ADDR_DEPTH: out_A[DEPTH_W-1:0] = depth;
            default:    out_A = '0;
        endcase
    end

    assign out_irq_req = req;
    assign out_irq_id  = cand_id;
    assign out_vector  = DATA_W'(VEC_BASE) + DATA_W'(cand_id) * DATA_W'(VEC_STRIDE);
    assign out_epc     = top_pc;
    assign out_IE      = ie;
    assign out_INM     = mask;
    assign out_depth   = depth;

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Bench for cp0_irq_ctrl: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the controller.
module tb_cp0_irq_ctrl;

    logic        in_CLK = 1'b0;
    logic        in_RST_N;
    logic        in_WE;
    logic [2:0]  in_rW;
    logic [31:0] in_W;
    logic [2:0]  in_rA;
    logic [31:0] out_A;
    logic [3:0]  in_irq;
    logic [31:0] in_pc;
    logic        in_ack;
    logic        in_eret;
    logic        out_irq_req;
    logic [1:0]  out_irq_id;
    logic [31:0] out_vector;
    logic [31:0] out_epc;
    logic        out_IE;
    logic [3:0]  out_INM;
    logic [2:0]  out_depth;

    cp0_irq_ctrl #(
        .DATA_W     (32),
        .NUM_IRQ    (4),
        .NEST_DEPTH (4),
        .IRQ_EDGE   (1'b1),
        .VEC_BASE   (32'h0000_0100),
        .VEC_STRIDE (16)
    ) dut (
        .in_CLK      (in_CLK),
        .in_RST_N    (in_RST_N),
        .in_WE       (in_WE),
        .in_rW       (in_rW),
        .in_W        (in_W),
        .in_rA       (in_rA),
        .out_A       (out_A),
        .in_irq      (in_irq),
        .in_pc       (in_pc),
        .in_ack      (in_ack),
        .in_eret     (in_eret),
        .out_irq_req (out_irq_req),
        .out_irq_id  (out_irq_id),
        .out_vector  (out_vector),
        .out_epc     (out_epc),
        .out_IE      (out_IE),
        .out_INM     (out_INM),
        .out_depth   (out_depth)
    );

    always #5 in_CLK = ~in_CLK;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: nesting frames kept in a queue, newest at the back.
    typedef struct {
        logic [31:0] pc;
        int          id;
    } frame_t;

    frame_t     m_stk[$];
    logic [3:0] m_pend;
    logic [3:0] m_mask;
    logic [3:0] m_irqq;
    logic       m_ie;
    logic       m_err;

    function automatic void m_reset();
        m_stk.delete();
        m_pend = '0;
        m_mask = '0;
        m_irqq = '0;
        m_ie   = 1'b1;
        m_err  = 1'b0;
    endfunction

    function automatic int m_top_id();
        return (m_stk.size() == 0) ? 0 : m_stk[m_stk.size()-1].id;
    endfunction

    function automatic logic [31:0] m_top_pc();
        return (m_stk.size() == 0) ? 32'h0 : m_stk[m_stk.size()-1].pc;
    endfunction

    function automatic int m_cand();
        for (int i = 0; i < 4; i++) begin
            if (m_pend[i] && m_mask[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic m_req();
        int c = m_cand();
        if (!m_ie || c < 0 || m_stk.size() >= 4) return 1'b0;
        if (m_stk.size() == 0) return 1'b1;
        return c < m_top_id();
    endfunction

    function automatic logic [31:0] m_rd(input logic [2:0] a);
        logic [31:0] r = '0;
        case (a)
            3'd0: r = {30'b0, m_err, m_ie};
            3'd1: r = {28'b0, m_mask};
            3'd2: begin
                r = {28'b0, m_pend};
                r[23:16] = 8'(m_top_id());
            end
            3'd3: r = m_top_pc();
            3'd4: r = 32'(m_stk.size());
            default: r = '0;
        endcase
        return r;
    endfunction

    // Advance the model by one rising edge using the inputs currently applied.
    function automatic void m_edge();
        logic       r     = m_req();
        int         c     = m_cand();
        logic       ack   = in_ack && r && !in_eret;
        logic [3:0] rise  = in_irq & ~m_irqq;
        logic       wr_s  = in_WE && (in_rW == 3'd0);
        logic       wr_m  = in_WE && (in_rW == 3'd1);
        logic       wr_c  = in_WE && (in_rW == 3'd2);
        logic       wr_e  = in_WE && (in_rW == 3'd3);
        logic       empty = (m_stk.size() == 0);
        frame_t     f;
        m_irqq = in_irq;
        if (ack) m_pend[c] = 1'b0;
        if (wr_c) m_pend = m_pend | in_W[3:0];
        m_pend = m_pend | rise;
        if (in_eret && empty) m_err = 1'b1;
        else if (wr_s && in_W[1]) m_err = 1'b0;
        if (ack) m_ie = 1'b0;
        else if (in_eret) m_ie = 1'b1;
        else if (wr_s) m_ie = in_W[0];
        if (wr_m) m_mask = in_W[3:0];
        if (ack) begin
            f.pc = in_pc;
            f.id = c;
            m_stk.push_back(f);
        end else if (in_eret) begin
            if (!empty) m_stk.delete(m_stk.size()-1);
        end else if (wr_e && !empty) begin
            m_stk[m_stk.size()-1].pc = in_W;
        end
    endfunction

    task automatic check_all();
        logic r = m_req();
        chk("req", 64'(out_irq_req), 64'(r));
        if (r) begin
            chk("id", 64'(out_irq_id), 64'(m_cand()));
            chk("vector", 64'(out_vector), 64'(32'h100 + 32'(16 * m_cand())));
        end
        chk("epc", 64'(out_epc), 64'(m_top_pc()));
        chk("ie", 64'(out_IE), 64'(m_ie));
        chk("inm", 64'(out_INM), 64'(m_mask));
        chk("depth", 64'(out_depth), 64'(m_stk.size()));
        chk("rdata", 64'(out_A), 64'(m_rd(in_rA)));
    endtask

    // One clock: compare on the falling edge, step the model on the rising edge.
    task automatic cyc();
        @(negedge in_CLK);
        check_all();
        @(posedge in_CLK);
        m_edge();
        #1;
    endtask

    task automatic idle();
        in_WE   = 1'b0;
        in_rW   = 3'd0;
        in_W    = '0;
        in_irq  = '0;
        in_ack  = 1'b0;
        in_eret = 1'b0;
        in_pc   = '0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        in_WE = 1'b1;
        in_rW = a;
        in_W  = d;
        cyc();
        in_WE = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] b);
        in_irq = b;
        cyc();
        in_irq = '0;
    endtask

    task automatic do_ack(input logic [31:0] pc);
        in_ack = 1'b1;
        in_pc  = pc;
        cyc();
        in_ack = 1'b0;
    endtask

    task automatic do_eret();
        in_eret = 1'b1;
        cyc();
        in_eret = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req"}, 64'(out_irq_req), 64'(0));
        chk({tag, "_epc"}, 64'(out_epc), 64'(0));
        chk({tag, "_ie"}, 64'(out_IE), 64'(1));
        chk({tag, "_inm"}, 64'(out_INM), 64'(0));
        chk({tag, "_depth"}, 64'(out_depth), 64'(0));
    endtask

    // Asynchronous reset mid-cycle, released just after a rising edge.
    task automatic mid_reset(input string tag);
        idle();
        #2;
        in_RST_N = 1'b0;
        #1;
        check_reset_vals(tag);
        m_reset();
        @(posedge in_CLK);
        #1;
        in_RST_N = 1'b1;
    endtask

    initial begin
        idle();
        in_rA    = 3'd0;
        in_RST_N = 1'b0;
        m_reset();
        #12;
        check_reset_vals("por");
        chk("por_status", 64'(out_A), 64'(32'h1));
        @(posedge in_CLK);
        #1;
        in_RST_N = 1'b1;

        // Single interrupt, ack and return.
        wr(3'd1, 32'h2);
        pulse(4'b0010);
        chk("plan_req", 64'(out_irq_req), 64'(1));
        chk("plan_id", 64'(out_irq_id), 64'(1));
        chk("plan_vec", 64'(out_vector), 64'(32'h110));
        do_ack(32'h40);
        chk("ack_depth", 64'(out_depth), 64'(1));
        chk("ack_epc", 64'(out_epc), 64'(32'h40));
        chk("ack_ie", 64'(out_IE), 64'(0));
        chk("ack_req", 64'(out_irq_req), 64'(0));
        do_eret();
        chk("eret_depth", 64'(out_depth), 64'(0));
        chk("eret_ie", 64'(out_IE), 64'(1));
        chk("eret_epc", 64'(out_epc), 64'(0));

        // Nesting: higher priority preempts, lower priority waits.
        wr(3'd1, 32'hF);
        pulse(4'b0100);
        do_ack(32'h20);
        wr(3'd0, 32'h1);
        pulse(4'b0001);
        chk("nest_req", 64'(out_irq_req), 64'(1));
        chk("nest_id", 64'(out_irq_id), 64'(0));
        do_ack(32'h88);
        chk("nest_depth", 64'(out_depth), 64'(2));
        chk("nest_epc", 64'(out_epc), 64'(32'h88));
        pulse(4'b1000);
        chk("nest_lowpri", 64'(out_irq_req), 64'(0));
        do_eret();
        do_eret();
        chk("unwind_id", 64'(out_irq_id), 64'(3));
        chk("unwind_req", 64'(out_irq_req), 64'(1));

        // Fill the stack with ids 3,2,1,0.
        do_ack(32'h100);
        wr(3'd0, 32'h1);
        pulse(4'b0100);
        do_ack(32'h104);
        wr(3'd0, 32'h1);
        pulse(4'b0010);
        do_ack(32'h108);
        wr(3'd0, 32'h1);
        pulse(4'b0001);
        do_ack(32'h10c);
        wr(3'd0, 32'h1);
        chk("full_depth", 64'(out_depth), 64'(4));
        pulse(4'b0001);
        chk("full_req", 64'(out_irq_req), 64'(0));
        in_rA = 3'd2;
        #1;
        chk("full_pend", 64'(out_A[0]), 64'(1));
        do_eret();
        chk("full_rereq", 64'(out_irq_req), 64'(1));
        chk("full_reid", 64'(out_irq_id), 64'(0));
        do_eret();
        do_eret();
        do_eret();

        // Underflowing eret sets ERR, write-1 clears it.
        in_rA = 3'd0;
        do_eret();
        chk("err_set", 64'(out_A[1]), 64'(1));
        chk("err_depth", 64'(out_depth), 64'(0));
        wr(3'd0, 32'h3);
        chk("err_clr", 64'(out_A[1]), 64'(0));

        // Software interrupt, then reset in the middle of its handler.
        wr(3'd1, 32'h8);
        wr(3'd2, 32'h8);
        chk("sw_req", 64'(out_irq_req), 64'(1));
        chk("sw_id", 64'(out_irq_id), 64'(3));
        do_ack(32'h55);
        chk("sw_depth", 64'(out_depth), 64'(1));
        mid_reset("midrst");

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) mid_reset("rndrst");
            in_WE   = ($urandom_range(0, 4) == 0);
            in_rW   = 3'($urandom_range(0, 7));
            in_W    = $urandom;
            in_W[0] = ($urandom_range(0, 3) != 0);
            in_irq  = 4'($urandom) & 4'($urandom);
            in_ack  = 1'($urandom_range(0, 1));
            in_eret = ($urandom_range(0, 7) == 0);
            in_pc   = $urandom;
            in_rA   = 3'($urandom_range(0, 7));
            cyc();
        end
        idle();
        cyc();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
